// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide sequencer.
// Handshake: a request is taken on a rising edge with req_valid=1, flush=0 and the sequencer idle; busy=1 means not ready.
interface muldiv_seq_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output req_valid, req_op, op_a, op_b, flush,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  req_valid, req_op, op_a, op_b, flush,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning the architectural HI/LO registers.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply (IDLE->DONE), MUL_CYCLES unused.
module muldiv_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_seq_if.slave    bus,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int CNT_MAX = (MUL_CYCLES > DIV_ITERS) ? MUL_CYCLES : DIV_ITERS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        hi_q, lo_q;
  logic               dz_q;
  logic [31:0]        rem_q, quo_q, dvsr_q;
  logic               neg_q_q, neg_r_q;

  logic               accept, is_mul, is_div, op_signed;
  logic [31:0]        a_mag, b_mag;
  logic [32:0]        shifted, trial;
  logic [31:0]        step_rem, step_quo, fix_rem, fix_quo;

  // Sign-extend to 64 bits; the low 64 bits of the product are then exact for both signednesses.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ea, eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

`ifndef MULDIV_FAST_MUL_EN
  logic [31:0] mul_a_q, mul_b_q;
  logic        mul_sgn_q;
  logic [63:0] prod;
  assign prod = mul64(mul_a_q, mul_b_q, mul_sgn_q);
`endif

  assign accept    = (state == S_IDLE) && bus.req_valid && !bus.flush;
  assign is_mul    = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
  assign is_div    = (bus.req_op == OP_DIV)  || (bus.req_op == OP_DIVU);
  assign op_signed = ~bus.req_op[0];
  assign a_mag     = (op_signed && bus.op_a[31]) ? -bus.op_a : bus.op_a;
  assign b_mag     = (op_signed && bus.op_b[31]) ? -bus.op_b : bus.op_b;

  // Restoring step: bit 32 of the trial subtract is the borrow.
  assign shifted  = {rem_q, quo_q[31]};
  assign trial    = shifted - {1'b0, dvsr_q};
  assign step_rem = trial[32] ? shifted[31:0] : trial[31:0];
  assign step_quo = {quo_q[30:0], ~trial[32]};
  assign fix_quo  = neg_q_q ? -quo_q : quo_q;
  assign fix_rem  = neg_r_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nx = S_DONE;
`else
          state_nx = S_MUL;
`endif
        end else if (accept && is_div) begin
          state_nx = (bus.op_b == 32'd0) ? S_DONE : S_DIV;
        end
      end
      S_MUL:   if (bus.flush) state_nx = S_IDLE; else if (cnt == '0) state_nx = S_DONE;
      S_DIV:   if (bus.flush) state_nx = S_IDLE; else if (cnt == '0) state_nx = S_FIX;
      S_FIX:   state_nx = bus.flush ? S_IDLE : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sgn_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          case (bus.req_op)
            OP_MULT, OP_MULTU: begin
              dz_q <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
              {hi_q, lo_q} <= mul64(bus.op_a, bus.op_b, op_signed);
`else
              mul_a_q   <= bus.op_a;
              mul_b_q   <= bus.op_b;
              mul_sgn_q <= op_signed;
              cnt       <= CNT_W'(MUL_CYCLES - 1);
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (bus.op_b == 32'd0) begin
                hi_q <= bus.op_a;
                lo_q <= 32'hFFFF_FFFF;
                dz_q <= 1'b1;
              end else begin
                dz_q    <= 1'b0;
                rem_q   <= '0;
                quo_q   <= a_mag;
                dvsr_q  <= b_mag;
                neg_q_q <= op_signed && (bus.op_a[31] ^ bus.op_b[31]);
                neg_r_q <= op_signed && bus.op_a[31];
                cnt     <= CNT_W'(DIV_ITERS - 1);
              end
            end
            OP_MTHI: hi_q <= bus.op_a;
            OP_MTLO: lo_q <= bus.op_a;
            default: ;
          endcase
        end
`ifndef MULDIV_FAST_MUL_EN
        S_MUL: if (!bus.flush) begin
          if (cnt == '0) {hi_q, lo_q} <= prod;
          else           cnt <= cnt - CNT_W'(1);
        end
`endif
        S_DIV: if (!bus.flush) begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_FIX: if (!bus.flush) begin
          hi_q <= fix_rem;
          lo_q <= fix_quo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = (state == S_DONE) && dz_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign dbg_state    = state;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS HI/LO arithmetic: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the architectural HI and LO registers. The EX-stage ALU reads them for MFHI/MFLO via hi_out/lo_out.
- Frees the single-cycle ALU from the 64-bit product path.
- The hazard unit stalls any MFHI/MFLO/MULT/DIV/MTHI/MTLO while busy=1.

Parameters:
- MUL_CYCLES, 4: cycles spent in MUL state before HI/LO write. Legal range 1..15.
- DIV_ITERS, 32: restoring-division iterations, one per cycle. Fixed at 32; a parameter for bench speed-up only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request from EX stage; sampled only when busy=0.
- req_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored (no effect).
- op_a  in  32  rs value: dividend / multiplicand / MTHI-MTLO source.
- op_b  in  32  rt value: divisor / multiplier.
- flush  in  1  pipeline flush (exception/SYSCALL); aborts an in-flight operation.
- busy  out  1  operation in flight; the hazard unit stalls on it.
- done  out  1  one-cycle pulse, asserted in the cycle HI/LO become visible after MUL/DIV.
- div_zero  out  1  one-cycle pulse together with done when the divisor was 0.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_zero=0; hi_out=0, lo_out=0; counter=0; internal operand regs=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + req_valid with MULT/MULTU:
  - Latch operands and signedness; counter=MUL_CYCLES-1; go to MUL.
  - busy=1 from the next cycle.
- MUL:
  - Counter decrements each cycle; at 0 go to DONE.
  - Product is signed or unsigned 32x32→64; HI=[63:32], LO=[31:0].
- IDLE + req_valid with DIV/DIVU:
  - Signed: latch magnitudes |op_a|, |op_b| and sign flags. Unsigned: raw values.
  - Counter=DIV_ITERS-1; go to DIV.
  - If op_b=0, go directly to DONE with the div_zero flag set.
- DIV: one restoring step per cycle (shift remainder:quotient, trial subtract, set quotient bit); at counter 0 go to FIX.
- FIX (1 cycle), signed only:
  - Negate quotient if the sign flags differ.
  - Negate remainder if the dividend was negative.
  - Result: quotient truncates toward zero; remainder takes the dividend's sign.
- DONE (1 cycle):
  - Write HI/LO (visible on hi_out/lo_out this cycle); done=1; go to IDLE. busy=0 in the DONE cycle.
  - A new request may be accepted in the cycle after DONE.
- Latency, measured from the accept edge to the done pulse:
  - MUL: MUL_CYCLES+1 cycles.
  - DIV: DIV_ITERS+2 cycles (34).
  - Divide by zero: 1 cycle.
- Divide by zero: HI=op_a, LO=0xFFFFFFFF, div_zero=1 with done.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no flag.
- MTHI/MTLO in IDLE: write HI or LO at the next edge; no busy, no done.
- req_valid while busy=1: ignored, with no effect on state or operands. The hazard unit guarantees a stall.
- flush:
  - In MUL/DIV/FIX: go to IDLE next cycle; HI/LO unchanged; no done.
  - In DONE: the write still completes (the instruction has already committed).
  - In IDLE: a simultaneous req_valid is dropped.
- rst mid-operation: everything returns to reset values at the next edge, regardless of state.
- Widths: the product is 64-bit exact. Divider remainder datapath is 33-bit to hold the trial-subtract borrow.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU go IDLE→DONE directly. The single-cycle 64-bit multiply is registered at accept, giving a 1-cycle done latency; MUL_CYCLES is ignored.
- Undefined: the MUL state with the MUL_CYCLES countdown is used as described above.
- Division timing is unaffected in both cases.

Test Plan:
- MULT op_a=0xFFFFFFFE (-2), op_b=3 → done 5 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV op_a=-7 (0xFFFFFFF9), op_b=2 → done 34 cycles after accept; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 → LO=14, HI=2.
- DIVU op_a=0x12345678, op_b=0 → done+div_zero 1 cycle after accept; HI=0x12345678, LO=0xFFFFFFFF.
- DIV op_a=0x80000000, op_b=0xFFFFFFFF → LO=0x80000000, HI=0, div_zero=0.
- MTHI 0xAAAA5555, then MTLO 0x1234 → next cycle each value appears on hi_out/lo_out; busy never asserts. Then start a DIV, pulse flush at cycle 10 → busy drops next cycle, no done, HI/LO still 0xAAAA5555/0x1234.
- During a MULT, assert req_valid with DIVU 9/3 → ignored; only the MULT result is written. rst at cycle 2 of a DIV → all outputs 0 next cycle, state IDLE.
